// File: rtl/snake_ram_arbiter.sv
// Two-requester arbiter for the single-port snake segment RAM: round-robin when free,
// locked updater bursts with a bounded starvation window for the draw scanner.
module snake_ram_arbiter #(
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 17,
    parameter int RD_LAT   = 1,
    parameter int LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              upd_req,
    input  logic              upd_we,
    input  logic              upd_lock,
    input  logic [ADDR_W-1:0] upd_addr,
    input  logic [DATA_W-1:0] upd_wdata,
    output logic              upd_gnt,
    output logic              upd_rvalid,
    output logic [DATA_W-1:0] upd_rdata,
    input  logic              drw_req,
    input  logic [ADDR_W-1:0] drw_addr,
    output logic              drw_gnt,
    output logic              drw_rvalid,
    output logic [DATA_W-1:0] drw_rdata,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);

    localparam int LOCK_W = $clog2(LOCK_MAX) + 1;

    typedef enum logic {FREE, UPD_LOCK} state_t;
    typedef enum logic {OWN_UPD, OWN_DRW} owner_t;
    typedef struct packed {
        logic   valid;
        owner_t owner;
    } tag_t;

    state_t              state, state_nxt;
    owner_t              last_owner;
    logic [LOCK_W-1:0]   lock_cnt, cnt_nxt;
    tag_t [RD_LAT:0]     tags;
    tag_t                new_tag;
    logic                lock_full;

    assign lock_full = (lock_cnt >= LOCK_W'(LOCK_MAX));

    always_comb begin
        state_nxt = state;
        cnt_nxt   = lock_cnt;
        upd_gnt   = 1'b0;
        drw_gnt   = 1'b0;
        unique case (state)
            FREE: begin
                if (upd_req && (!drw_req || last_owner == OWN_DRW))
                    upd_gnt = 1'b1;
                else if (drw_req)
                    drw_gnt = 1'b1;
                if (upd_gnt && upd_lock) begin
                    state_nxt = UPD_LOCK;
                    cnt_nxt   = LOCK_W'(1);
                end
            end
            UPD_LOCK: begin
                // Exiting the lock is same-cycle, so a waiting draw read is served at once.
                if (!upd_req) begin
                    drw_gnt   = drw_req;
                    state_nxt = FREE;
                    cnt_nxt   = '0;
                end else if (!drw_req || !lock_full) begin
                    upd_gnt = 1'b1;
                    if (!upd_lock) begin
                        state_nxt = FREE;
                        cnt_nxt   = '0;
                    end else if (!lock_full) begin
                        cnt_nxt = lock_cnt + LOCK_W'(1);
                    end
                end else begin
                    drw_gnt = 1'b1;
                    cnt_nxt = '0;
                end
            end
            default: state_nxt = FREE;
        endcase
        if (!reset_n) begin
            upd_gnt = 1'b0;
            drw_gnt = 1'b0;
        end
    end

    always_comb begin
        new_tag.valid = drw_gnt || (upd_gnt && !upd_we);
        new_tag.owner = drw_gnt ? OWN_DRW : OWN_UPD;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= FREE;
            last_owner  <= OWN_DRW;
            lock_cnt    <= '0;
            ram_address <= '0;
            ram_data    <= '0;
            ram_wren    <= 1'b0;
            tags        <= '0;
        end else begin
            state    <= state_nxt;
            lock_cnt <= cnt_nxt;
            ram_wren <= upd_gnt && upd_we;
            if (upd_gnt) begin
                last_owner  <= OWN_UPD;
                ram_address <= upd_addr;
                if (upd_we)
                    ram_data <= upd_wdata;
            end else if (drw_gnt) begin
                last_owner  <= OWN_DRW;
                ram_address <= drw_addr;
            end
            tags[0] <= new_tag;
            for (int unsigned i = 1; i <= RD_LAT; i++)
                tags[i] <= tags[i-1];
        end
    end

    assign upd_rvalid = tags[RD_LAT].valid && (tags[RD_LAT].owner == OWN_UPD);
    assign drw_rvalid = tags[RD_LAT].valid && (tags[RD_LAT].owner == OWN_DRW);
    assign upd_rdata  = upd_rvalid ? ram_q : '0;
    assign drw_rdata  = drw_rvalid ? ram_q : '0;

endmodule

// File: tb/tb_snake_ram_arbiter.sv
// Directed bench: two arbiter instances (RD_LAT 1 and 2) share stimulus, each with its own RAM model.
module tb_snake_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        upd_req, upd_we, upd_lock, drw_req;
    logic [10:0] upd_addr, drw_addr;
    logic [16:0] upd_wdata;

    logic        upd_gnt1, upd_rvalid1, drw_gnt1, drw_rvalid1, ram_wren1;
    logic [16:0] upd_rdata1, drw_rdata1, ram_data1, ram_q1;
    logic [10:0] ram_address1;
    logic        upd_gnt2, upd_rvalid2, drw_gnt2, drw_rvalid2, ram_wren2;
    logic [16:0] upd_rdata2, drw_rdata2, ram_data2, ram_q2;
    logic [10:0] ram_address2;

    logic [16:0] mem1 [0:2047];
    logic [16:0] mem2 [0:2047];
    logic [16:0] q2_s0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    snake_ram_arbiter #(.ADDR_W(11), .DATA_W(17), .RD_LAT(1), .LOCK_MAX(16)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .upd_req(upd_req), .upd_we(upd_we), .upd_lock(upd_lock), .upd_addr(upd_addr),
        .upd_wdata(upd_wdata), .upd_gnt(upd_gnt1), .upd_rvalid(upd_rvalid1), .upd_rdata(upd_rdata1),
        .drw_req(drw_req), .drw_addr(drw_addr), .drw_gnt(drw_gnt1), .drw_rvalid(drw_rvalid1),
        .drw_rdata(drw_rdata1), .ram_address(ram_address1), .ram_data(ram_data1),
        .ram_wren(ram_wren1), .ram_q(ram_q1)
    );

    snake_ram_arbiter #(.ADDR_W(11), .DATA_W(17), .RD_LAT(2), .LOCK_MAX(16)) dut2 (
        .clk(clk), .reset_n(reset_n),
        .upd_req(upd_req), .upd_we(upd_we), .upd_lock(upd_lock), .upd_addr(upd_addr),
        .upd_wdata(upd_wdata), .upd_gnt(upd_gnt2), .upd_rvalid(upd_rvalid2), .upd_rdata(upd_rdata2),
        .drw_req(drw_req), .drw_addr(drw_addr), .drw_gnt(drw_gnt2), .drw_rvalid(drw_rvalid2),
        .drw_rdata(drw_rdata2), .ram_address(ram_address2), .ram_data(ram_data2),
        .ram_wren(ram_wren2), .ram_q(ram_q2)
    );

    function automatic logic [16:0] init_word(input int unsigned a);
        logic [31:0] t;
        t = a * 37 + 341;
        return t[16:0] ^ 17'h15A5A;
    endfunction

    // New-data-on-read RAM models, one and two cycles of read latency.
    always @(posedge clk) begin
        if (ram_wren1) mem1[ram_address1] <= ram_data1;
        ram_q1 <= ram_wren1 ? ram_data1 : mem1[ram_address1];
        if (ram_wren2) mem2[ram_address2] <= ram_data2;
        q2_s0  <= ram_wren2 ? ram_data2 : mem2[ram_address2];
        ram_q2 <= q2_s0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        upd_req  = 1'b0;
        upd_we   = 1'b0;
        upd_lock = 1'b0;
        drw_req  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a;
        logic ev_u, ev_d;
        logic [10:0] ea;

        for (int i = 0; i < 2048; i++) begin
            mem1[i] = init_word(i);
            mem2[i] = init_word(i);
        end
        ram_q1 = '0; ram_q2 = '0; q2_s0 = '0;
        reset_n = 1'b0;
        idle();
        upd_addr = '0; drw_addr = '0; upd_wdata = '0;

        // Reset state, grant suppressed while in reset
        tick(); tick();
        upd_req = 1'b1;
        #1;
        check("rst_upd_gnt", upd_gnt1, 0);
        check("rst_drw_gnt", drw_gnt1, 0);
        check("rst_ram_address", ram_address1, 0);
        check("rst_ram_wren", ram_wren1, 0);
        check("rst_ram_data", ram_data1, 0);
        check("rst_upd_rvalid", upd_rvalid1, 0);
        check("rst_drw_rvalid", drw_rvalid1, 0);
        check("rst2_ram_address", ram_address2, 0);
        upd_req = 1'b0;
        reset_n = 1'b1;

        // Single uncontended updater read of address 5
        tick();
        upd_req = 1'b1; upd_we = 1'b0; upd_addr = 11'd5;
        #1;
        check("t1_upd_gnt", upd_gnt1, 1);
        check("t1_drw_gnt", drw_gnt1, 0);
        tick(); idle(); #1;
        check("t1_ram_address", ram_address1, 5);
        check("t1_ram_wren", ram_wren1, 0);
        check("t1_rvalid_early", upd_rvalid1, 0);
        tick(); #1;
        check("t1_upd_rvalid", upd_rvalid1, 1);
        check("t1_upd_rdata", upd_rdata1, init_word(5));
        check("t1_drw_rvalid", drw_rvalid1, 0);
        check("t1_lat2_early", upd_rvalid2, 0);
        tick(); #1;
        check("t1_rvalid_pulse", upd_rvalid1, 0);
        check("t1_lat2_rvalid", upd_rvalid2, 1);
        check("t1_lat2_rdata", upd_rdata2, init_word(5));

        // Round-robin: a draw read first, then both requesting for 6 cycles
        tick();
        drw_req = 1'b1; drw_addr = 11'd7;
        #1;
        check("t2_setup_drw_gnt", drw_gnt1, 1);
        check("t2_setup_upd_gnt", upd_gnt1, 0);
        for (int c = 0; c < 8; c++) begin
            tick();
            if (c < 6) begin
                upd_req = 1'b1; upd_we = 1'b0; upd_addr = 11'(10 + c);
                drw_req = 1'b1; drw_addr = 11'(20 + c);
            end else begin
                idle();
            end
            #1;
            if (c < 6) begin
                check($sformatf("t2_upd_gnt_%0d", c), upd_gnt1, (c % 2 == 0));
                check($sformatf("t2_drw_gnt_%0d", c), drw_gnt1, (c % 2 == 1));
            end
            a = c - 2;
            ev_u = (a >= 0) && (a % 2 == 0);
            ev_d = (a == -1) || ((a >= 0) && (a % 2 == 1));
            ea = (a == -1) ? 11'd7 : ((a % 2 == 0) ? 11'(10 + a) : 11'(20 + a));
            check($sformatf("t2_upd_rvalid_%0d", c), upd_rvalid1, ev_u);
            check($sformatf("t2_drw_rvalid_%0d", c), drw_rvalid1, ev_d);
            if (ev_u) check($sformatf("t2_upd_rdata_%0d", c), upd_rdata1, init_word(ea));
            if (ev_d) check($sformatf("t2_drw_rdata_%0d", c), drw_rdata1, init_word(ea));
        end

        // Write then read-back of address 0
        tick();
        upd_req = 1'b1; upd_we = 1'b1; upd_addr = 11'd0; upd_wdata = 17'h0A14A;
        #1;
        check("t3_wr_gnt", upd_gnt1, 1);
        tick();
        upd_we = 1'b0;
        #1;
        check("t3_rd_gnt", upd_gnt1, 1);
        check("t3_ram_wren", ram_wren1, 1);
        check("t3_ram_data", ram_data1, 17'h0A14A);
        check("t3_ram_address", ram_address1, 0);
        tick(); idle(); #1;
        check("t3_wren_pulse", ram_wren1, 0);
        check("t3_ram_data_hold", ram_data1, 17'h0A14A);
        check("t3_no_write_rvalid", upd_rvalid1, 0);
        tick(); #1;
        check("t3_upd_rvalid", upd_rvalid1, 1);
        check("t3_upd_rdata", upd_rdata1, 17'h0A14A);
        tick(); #1;
        check("t3_lat2_rdata", upd_rdata2, 17'h0A14A);

        // Locked burst of 20 with draw pending: 16 updater, 1 draw, updater resumes
        tick();
        drw_req = 1'b1; drw_addr = 11'd40;
        #1;
        check("t4_setup_drw_gnt", drw_gnt1, 1);
        for (int k = 0; k < 20; k++) begin
            tick();
            upd_req = 1'b1; upd_lock = 1'b1; upd_we = 1'b0; upd_addr = 11'(100 + k);
            drw_req = 1'b1; drw_addr = 11'd50;
            #1;
            check($sformatf("t4_upd_gnt_%0d", k), upd_gnt1, (k != 16));
            check($sformatf("t4_drw_gnt_%0d", k), drw_gnt1, (k == 16));
        end
        tick(); idle(); #1;
        check("t4_release_upd_gnt", upd_gnt1, 0);
        check("t4_release_drw_gnt", drw_gnt1, 0);

        // Short lock of 3 then an unlocked 4th; draw must follow immediately
        tick();
        drw_req = 1'b1; drw_addr = 11'd60;
        #1;
        check("t5_setup_drw_gnt", drw_gnt1, 1);
        for (int k = 0; k < 6; k++) begin
            tick();
            upd_req = 1'b1; upd_lock = (k < 3); upd_we = 1'b0; upd_addr = 11'(200 + k);
            drw_req = 1'b1;
            #1;
            check($sformatf("t5_upd_gnt_%0d", k), upd_gnt1, (k != 4));
            check($sformatf("t5_drw_gnt_%0d", k), drw_gnt1, (k == 4));
        end
        tick(); idle(); #1;
        tick(); tick(); tick();

        // Reset one cycle after a draw read on the RD_LAT=2 instance
        tick();
        drw_req = 1'b1; drw_addr = 11'd33;
        #1;
        check("t6_drw_gnt", drw_gnt2, 1);
        tick();
        drw_req = 1'b0; upd_req = 1'b1;
        reset_n = 1'b0;
        #1;
        check("t6_upd_gnt", upd_gnt2, 0);
        check("t6_drw_gnt_rst", drw_gnt2, 0);
        check("t6_ram_address", ram_address2, 0);
        check("t6_ram_wren", ram_wren2, 0);
        check("t6_ram_data", ram_data2, 0);
        check("t6_upd_rvalid", upd_rvalid2, 0);
        check("t6_drw_rvalid", drw_rvalid2, 0);
        check("t6_drw_rdata", drw_rdata2, 0);
        upd_req = 1'b0;
        #2;
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("t6_post_drw_rvalid2_%0d", k), drw_rvalid2, 0);
            check($sformatf("t6_post_drw_rvalid1_%0d", k), drw_rvalid1, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/snake_ram_arbiter.md
# snake_ram_arbiter

Arbiter that shares the single-port snake segment RAM (11-bit address, 17-bit word {type[1:0], x[7:0], y[6:0]}) between two requesters. The requesters are the body-update sequencer (read/write) and the VGA draw scanner (read-only). It sits between both requesters and the RAM port. It provides per-requester request/grant handshakes, routes read data back with a valid strobe, and supports locked bursts so an update sweep is not interleaved with draw reads.

## Interface
- ADDR_W, 11, RAM address width
- DATA_W, 17, RAM word width
- RD_LAT, 1, RAM read latency in cycles from address-registered to ram_q valid; legal values 1 or 2
- LOCK_MAX, 16, maximum consecutive locked updater grants while drw_req is pending
- clk  in  1  system clock; all state on posedge clk
- reset_n  in  1  asynchronous, active-low reset
- upd_req  in  1  updater access request
- upd_we  in  1  updater write enable, qualified by upd_req
- upd_lock  in  1  updater asks to keep ownership after the current access
- upd_addr  in  ADDR_W  updater address
- upd_wdata  in  DATA_W  updater write data
- upd_gnt  out  1  updater access accepted this cycle
- upd_rvalid  out  1  upd_rdata valid, one-cycle pulse per accepted updater read
- upd_rdata  out  DATA_W  read data to updater
- drw_req  in  1  draw scanner read request
- drw_addr  in  ADDR_W  draw address
- drw_gnt  out  1  draw access accepted this cycle
- drw_rvalid  out  1  drw_rdata valid pulse
- drw_rdata  out  DATA_W  read data to draw scanner
- ram_address  out  ADDR_W  registered RAM address
- ram_data  out  DATA_W  registered RAM write data
- ram_wren  out  1  registered RAM write enable
- ram_q  in  DATA_W  RAM read data

## Operation
- Acceptance: an access is accepted in the cycle where X_req and X_gnt are both high. upd_gnt and drw_gnt are combinational from the requests and arbiter state, and are never both high. Requesters must not derive req combinationally from gnt.
- State machine has two states, FREE and UPD_LOCK, plus a last_owner bit, a lock counter lock_cnt (width clog2(LOCK_MAX)+1), and a tag pipeline RD_LAT+1 deep. Each tag entry is {valid, owner}.
- FREE, only one requester active: that requester is granted.
- FREE, both requesting: grant goes to the requester that is not last_owner (round-robin).
- FREE → UPD_LOCK: taken when the updater access is accepted with upd_lock=1. lock_cnt←1.
- UPD_LOCK, granting the updater: if upd_req=1 and (drw_req=0 or lock_cnt<LOCK_MAX), the updater is granted. lock_cnt increments, saturating at LOCK_MAX.
- UPD_LOCK → FREE, immediately in the same cycle:
  - upd_req=0, or an updater access is accepted with upd_lock=0: the arbiter returns to FREE. lock_cnt←0.
  - lock_cnt==LOCK_MAX with drw_req=1: the draw scanner gets exactly one slot. State stays UPD_LOCK and lock_cnt←0.
- last_owner updates on every accepted access.
- Accepted access drives the RAM port on the next edge:
  - ram_address←addr.
  - ram_data←upd_wdata for updater writes, else hold the previous value.
  - ram_wren←(updater and upd_we).
- With no accepted access, ram_wren←0 and ram_address holds.
- Reads: every accepted read pushes {1, owner} into the tag pipeline; writes push {0, x}.
- X_rdata is ram_q routed combinationally. It is valid only while X_rvalid=1; otherwise it is don't-care.
- Writes produce no rvalid.
- Reset: all outputs 0, state FREE, last_owner=draw (updater wins the first tie), lock_cnt=0, all tags invalid.
- Reset asserted mid-operation: in-flight reads are dropped and no rvalid is emitted after reset release.

## Timing
- Accept at cycle N → ram_address/ram_wren valid during cycle N+1. A write commits at the edge ending N+1.
- Read accepted at cycle N → X_rvalid high in cycle N+1+RD_LAT only, with rdata=ram_q.
- Throughput is one access per cycle. Back-to-back reads from alternating owners return in issue order, each rvalid routed to its owner.
- Read-after-write to the same address on consecutive accepts returns the new data; the RAM port is configured new-data on read.
- Zero-cycle grant when the arbiter is free and uncontended.

## Test plan
- Reset, then upd_req=1, upd_we=0, upd_addr=5 with drw_req=0, RD_LAT=1 → upd_gnt same cycle, ram_address=5 next cycle, upd_rvalid pulse 2 cycles after accept, drw_rvalid stays 0.
- upd_req and drw_req held high, no lock, for 6 cycles → grants alternate upd, drw, upd, drw, upd, drw; rvalids return in the same order with correct owners.
- Updater writes 17'h0A14A to addr 0, then reads addr 0 on the next cycle → ram_wren=1 for one cycle, upd_rdata=17'h0A14A.
- upd_lock=1 and upd_req=1 held for 20 accesses while drw_req=1 → 16 consecutive upd_gnt, then one drw_gnt, then the updater resumes.
- upd_lock=1 burst of 3 then upd_lock=0 on the 4th access, with drw_req pending → drw_gnt in the cycle after the 4th updater accept.
- Assert reset_n=0 one cycle after a draw read accept (RD_LAT=2) → all outputs 0 immediately, and no drw_rvalid after release.
